// File: rtl/led_pwm_fader.sv
// led_pwm_fader: PWM output stage for the active-low board LEDs.
// It latches the LED pattern and the duty value once per PWM period, so
// the outputs never glitch. In breathing mode a tick-driven FSM ramps the
// brightness up, holds it, ramps it down and holds it again.
// Build option: define LED_PWM_GAMMA_EN for square-law duty mapping
// (duty = level*(level+1) >> PWM_BITS); otherwise duty follows level linearly.

module led_pwm_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic load,     // period boundary: capture the new pattern bit
  input  logic pat_in,
  input  logic cmp_on,   // pwm_cnt < duty, shared by all lanes
  output logic led       // active-low drive
);
  logic pat_q;

  // Pattern bit is held for the whole period; LED drive is registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q <= 1'b0;
      led   <= 1'b1;
    end else begin
      if (load) pat_q <= pat_in;
      led <= ~(pat_q & cmp_on);
    end
  end
endmodule

module led_pwm_fader #(
  parameter int LED_COUNT  = 6,
  parameter int PWM_BITS   = 8,
  parameter int HOLD_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [LED_COUNT-1:0] pattern,
  input  logic                 mode,
  input  logic [PWM_BITS-1:0]  brightness,
  output logic [LED_COUNT-1:0] led_output,
  output logic [PWM_BITS-1:0]  duty,
  output logic                 period_start
);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RISE    = 3'd1,
    S_HOLD_HI = 3'd2,
    S_FALL    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [PWM_BITS-1:0] level, level_nx;
  logic [HW-1:0]       hold_cnt, hold_nx;
  logic                hold_done;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] src_level;
  logic [PWM_BITS-1:0] duty_next;
  logic                cnt_zero;
  logic                cmp_on;

  // Hold ends on the tick that brings the counter to HOLD_TICKS-1;
  // with HOLD_TICKS == 1 the first tick in a hold state ends it
  assign hold_done = (HOLD_LAST == '0) || ((hold_cnt + HW'(1)) == HOLD_LAST);

  // Fade FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      level    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      level    <= level_nx;
      hold_cnt <= hold_nx;
    end
  end

  // Fade FSM next state: static mode parks in IDLE, breathing steps on tick
  always_comb begin
    state_nx = state;
    level_nx = level;
    hold_nx  = hold_cnt;
    if (!mode) begin
      state_nx = S_IDLE;
      level_nx = brightness;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_RISE;
          level_nx = '0;
          hold_nx  = '0;
        end
        S_RISE: if (tick) begin
          if (level >= brightness) begin
            level_nx = brightness;
            state_nx = S_HOLD_HI;
            hold_nx  = '0;
          end else if (level != LVL_MAX) begin
            level_nx = level + 1'b1;
          end
        end
        S_HOLD_HI, S_HOLD_LO: if (tick) begin
          hold_nx = hold_cnt + 1'b1;
          if (hold_done) state_nx = (state == S_HOLD_HI) ? S_FALL : S_RISE;
        end
        S_FALL: if (tick) begin
          if (level == '0) begin
            state_nx = S_HOLD_LO;
            hold_nx  = '0;
          end else begin
            level_nx = level - 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Static mode takes brightness directly so a new period never sees a stale level
  assign src_level = mode ? level : brightness;

`ifdef LED_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq        = {{PWM_BITS{1'b0}}, src_level} * ({{PWM_BITS{1'b0}}, src_level} + 1'b1);
  assign duty_next = PWM_BITS'(sq >> PWM_BITS);
`else
  assign duty_next = src_level;
`endif

  assign cnt_zero = (pwm_cnt == '0);
  assign cmp_on   = (pwm_cnt < duty);

  // PWM period counter and per-period duty latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt      <= '0;
      duty         <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= cnt_zero;
      if (cnt_zero) duty <= duty_next;
      pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
    end
  end

  genvar i;
  generate
    for (i = 0; i < LED_COUNT; i++) begin : g_lane
      led_pwm_lane u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_zero),
        .pat_in (pattern[i]),
        .cmp_on (cmp_on),
        .led    (led_output[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader (LED_COUNT=6, PWM_BITS=8, HOLD_TICKS=4).
module tb_led_pwm_fader;
  logic       clk = 1'b0;
  logic       rst_n, tick, mode;
  logic [5:0] pattern;
  logic [7:0] brightness;
  logic [5:0] led_output;
  logic [7:0] duty;
  logic       period_start;

  int errors = 0;
  int checks = 0;

  led_pwm_fader #(.LED_COUNT(6), .PWM_BITS(8), .HOLD_TICKS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .pattern      (pattern),
    .mode         (mode),
    .brightness   (brightness),
    .led_output   (led_output),
    .duty         (duty),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance to the cycle in which period_start is high (bounded)
  task automatic wait_ps(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (period_start) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // Sample one full period after a period_start
  task automatic run_period(output int low0, output int others_low, output int ps_idx);
    low0 = 0; others_low = 0; ps_idx = -1;
    for (int i = 1; i <= 255; i++) begin
      step(1);
      if (!led_output[0]) low0++;
      if (led_output[5:1] != 5'h1F) others_low++;
      if (period_start && ps_idx < 0) ps_idx = i;
    end
  endtask

  task automatic do_tick;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int low0, oth, psi, hi_cnt, low1;
    int exp_lvl[15] = '{1, 2, 3, 3, 3, 3, 3, 2, 1, 0, 0, 0, 0, 0, 1};
    int exp_st[15]  = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 1, 1};
    int gb[3]       = '{255, 128, 16};
`ifdef LED_PWM_GAMMA_EN
    int gd[3]       = '{255, 64, 1};
`else
    int gd[3]       = '{255, 128, 16};
`endif

    rst_n = 1'b0; tick = 1'b0; mode = 1'b0;
    pattern = 6'h3F; brightness = 8'd255;

    // Reset state
    step(3);
    chk("rst_led", 32'(led_output), 32'h3F);
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_ps", 32'(period_start), 32'd0);
    chk("rst_level", 32'(dut.level), 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("first_ps", 32'(period_start), 32'd1);
    chk("first_duty", 32'(duty), 32'd255);
    chk("first_led_off", 32'(led_output), 32'h3F);
    step(1);
    chk("solid_on", 32'(led_output), 32'h00);
    chk("ps_pulse_one", 32'(period_start), 32'd0);
    hi_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (led_output != 6'h00) hi_cnt++;
    end
    chk("solid_on_300", 32'(hi_cnt), 32'd0);

    // Static duty 64 on lane 0
    brightness = 8'd64; pattern = 6'b000001;
    wait_ps("ps_b64");
    chk("duty_b64", 32'(duty), 32'd64);
    run_period(low0, oth, psi);
    chk("low_b64", 32'(low0), 32'd64);
    chk("others_b64", 32'(oth), 32'd0);
    chk("period_b64", 32'(psi), 32'd255);

    // Static duty 0: never lit
    brightness = 8'd0;
    wait_ps("ps_b0");
    run_period(low0, oth, psi);
    chk("low_b0", 32'(low0), 32'd0);
    chk("others_b0", 32'(oth), 32'd0);

    // Pattern change mid-period is deferred to the next period
    brightness = 8'd128;
    wait_ps("ps_b128");
    low0 = 0; low1 = 0;
    for (int i = 1; i <= 254; i++) begin
      step(1);
      if (!led_output[0]) low0++;
      if (!led_output[1]) low1++;
      if (i == 10) pattern = 6'b000010;
    end
    step(1);
    chk("pat_ps", 32'(period_start), 32'd1);
    chk("pat_old_last", 32'(led_output), 32'h3E);
    chk("pat_low0", 32'(low0 + 1), 32'd128);
    chk("pat_low1", 32'(low1), 32'd0);
    step(1);
    chk("pat_new", 32'(led_output), 32'h3D);

    // Breathing, peak 3
    brightness = 8'd3; mode = 1'b1;
    step(1);
    chk("br_enter_st", 32'(dut.state), 32'd1);
    chk("br_enter_lvl", 32'(dut.level), 32'd0);
    step(9);
    for (int k = 0; k < 15; k++) begin
      do_tick();
      chk($sformatf("br_lvl_t%0d", k + 1), 32'(dut.level), 32'(exp_lvl[k]));
      chk($sformatf("br_st_t%0d", k + 1), 32'(dut.state), 32'(exp_st[k]));
      step(9);
    end

    // Breathing with zero peak
    mode = 1'b0; brightness = 8'd0;
    step(1);
    chk("z_idle", 32'(dut.state), 32'd0);
    mode = 1'b1;
    step(1);
    chk("z_rise", 32'(dut.state), 32'd1);
    do_tick();
    chk("z_hold_st", 32'(dut.state), 32'd2);
    chk("z_hold_lvl", 32'(dut.level), 32'd0);

    // Drop mode during FALL
    mode = 1'b0; brightness = 8'd3;
    step(1);
    mode = 1'b1;
    step(1);
    for (int k = 0; k < 8; k++) begin
      do_tick();
      step(2);
    end
    chk("fall_st", 32'(dut.state), 32'd3);
    chk("fall_lvl", 32'(dut.level), 32'd2);
    brightness = 8'd200; mode = 1'b0;
    step(1);
    chk("drop_idle", 32'(dut.state), 32'd0);
    chk("drop_lvl", 32'(dut.level), 32'd200);

    // Duty mapping (linear or gamma build)
    pattern = 6'h3F;
    for (int k = 0; k < 3; k++) begin
      brightness = 8'(gb[k]);
      wait_ps($sformatf("ps_g%0d", gb[k]));
      chk($sformatf("duty_g%0d", gb[k]), 32'(duty), 32'(gd[k]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
